// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: reads two bytes at PC/PC+1 and loads them low-then-high into the 8-bit IR port.
// Optional IFU_WORD_OUT_EN adds a Word/WordValid output with the assembled instruction.
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [7:0]        MemData,
  output logic [7:0]        IRData,
  output logic              IRWrite,
  output logic              IRLH,
  output logic              PCInc,
  output logic              Busy,
`ifdef IFU_WORD_OUT_EN
  output logic [15:0]       Word,
  output logic              WordValid,
`endif
  output logic              Done
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    WR_LO = 3'd2,
    RD_HI = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0] memaddr_q, memaddr_d;
  logic [7:0]        irdata_q, irdata_d;
  logic              memread_q, memread_d;
  logic              irwrite_q, irwrite_d;
  logic              irlh_q, irlh_d;
  logic              pcinc_q, pcinc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept_s;
  logic              rd_last_s;
`ifdef IFU_WORD_OUT_EN
  logic [7:0]        lo_byte_q, lo_byte_d;
  logic [15:0]       word_q, word_d;
  logic              wordvalid_q, wordvalid_d;
`endif

  // State and wait-counter register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      wait_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; Start is only looked at in IDLE and DONE
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (Start) state_d = RD_LO;
        else       state_d = IDLE;
      end
      RD_LO, RD_HI: begin
        if (wait_q == LAST) begin
          state_d = (state_q == RD_LO) ? WR_LO : WR_HI;
          wait_d  = {CNT_W{1'b0}};
        end else begin
          wait_d  = wait_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      WR_LO: state_d = RD_HI;
      WR_HI: state_d = DONE;
      DONE: begin
        if (Start) state_d = RD_LO;
        else       state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wait_d  = {CNT_W{1'b0}};
      end
    endcase
  end

  assign accept_s  = Start && ((state_q == IDLE) || (state_q == DONE));
  assign rd_last_s = ((state_q == RD_LO) || (state_q == RD_HI)) && (wait_q == LAST);

  // Output next values, decoded from the upcoming state so every output is a flop
  always_comb begin
    memaddr_d = memaddr_q;
    irdata_d  = irdata_q;
    if (accept_s) begin
      memaddr_d = PC;
    end else if (state_q == WR_LO) begin
      memaddr_d = memaddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      memaddr_d = memaddr_q;
    end
    if (rd_last_s) irdata_d = MemData;
    else           irdata_d = irdata_q;
    memread_d = (state_d == RD_LO) || (state_d == RD_HI);
    irwrite_d = (state_d == WR_LO) || (state_d == WR_HI);
    irlh_d    = (state_d == WR_HI);
    pcinc_d   = irwrite_d;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  // Output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      memaddr_q <= {ADDR_W{1'b0}};
      irdata_q  <= 8'h00;
      memread_q <= 1'b0;
      irwrite_q <= 1'b0;
      irlh_q    <= 1'b0;
      pcinc_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      memaddr_q <= memaddr_d;
      irdata_q  <= irdata_d;
      memread_q <= memread_d;
      irwrite_q <= irwrite_d;
      irlh_q    <= irlh_d;
      pcinc_q   <= pcinc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign MemAddr = memaddr_q;
  assign MemRead = memread_q;
  assign IRData  = irdata_q;
  assign IRWrite = irwrite_q;
  assign IRLH    = irlh_q;
  assign PCInc   = pcinc_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

`ifdef IFU_WORD_OUT_EN
  // IRData is overwritten by the high byte, so the low byte is kept aside during WR_LO
  always_comb begin
    lo_byte_d   = (state_q == WR_LO) ? irdata_q : lo_byte_q;
    word_d      = (state_q == WR_HI) ? {irdata_q, lo_byte_q} : word_q;
    wordvalid_d = (state_d == DONE);
  end

  // Assembled-word registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lo_byte_q   <= 8'h00;
      word_q      <= 16'h0000;
      wordvalid_q <= 1'b0;
    end else begin
      lo_byte_q   <= lo_byte_d;
      word_q      <= word_d;
      wordvalid_q <= wordvalid_d;
    end
  end

  assign Word      = word_q;
  assign WordValid = wordvalid_q;
`endif

endmodule
